// File: rtl/arbitro_pkg.sv
// Shared constants and width helpers for the transaction-layer arbiter and its neighbours.
package arbitro_pkg;

  localparam int DEF_NUM_IN    = 4;
  localparam int DEF_NUM_OUT   = 4;
  localparam int DEF_DATA_W    = 6;
  localparam int DEF_CLASS_LSB = 4;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Both helpers keep a minimum width of 1 so degenerate sizes still elaborate.
  function automatic int class_w(input int num_out);
    return (num_out > 1) ? clog2(num_out) : 1;
  endfunction

  function automatic int idx_w(input int num_in);
    return (num_in > 1) ? clog2(num_in) : 1;
  endfunction

endpackage

// File: rtl/arbitro_rr_pick.sv
// Rotating priority picker: first set bit of elig starting at ptr, wrapping modulo N.
module arbitro_rr_pick
  import arbitro_pkg::*;
#(
  parameter int N     = DEF_NUM_IN,
  parameter int IDX_W = idx_w(DEF_NUM_IN)
) (
  input  logic [N-1:0]     elig,
  input  logic [IDX_W-1:0] ptr,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx
);

  // Walk offsets from the far end so the smallest offset from ptr wins last.
  always_comb begin
    int s;
    gnt_valid = 1'b0;
    gnt_idx   = ptr;
    for (int k = N - 1; k >= 0; k--) begin
      s = int'(ptr) + k;
      if (s >= N) s = s - N;
      if (elig[s]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IDX_W'(s);
      end
    end
  end

endmodule

// File: rtl/arbitro_rr.sv
// Round-robin class router: pops one input FIFO per cycle and pushes the word to its class output.
// Define ARB_STRICT_PRIO_EN for fixed lowest-index-first priority instead of round-robin.
module arbitro_rr
  import arbitro_pkg::*;
#(
  parameter int NUM_IN    = DEF_NUM_IN,
  parameter int NUM_OUT   = DEF_NUM_OUT,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int CLASS_LSB = DEF_CLASS_LSB
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [NUM_IN-1:0]           fifo_empty,
  input  logic [NUM_IN*DATA_W-1:0]    head_data,
  input  logic [NUM_OUT-1:0]          almost_full,
  output logic [NUM_IN-1:0]           pop,
  output logic [NUM_OUT-1:0]          push,
  output logic [DATA_W-1:0]           data_out,
  output logic [idx_w(NUM_IN)-1:0]    grant_idx
);

  localparam int CLASS_W = class_w(NUM_OUT);
  localparam int IDX_W   = idx_w(NUM_IN);

  logic [DATA_W-1:0]  head_w [NUM_IN];
  logic [CLASS_W-1:0] cls    [NUM_IN];
  logic [NUM_IN-1:0]  elig;

  logic [NUM_IN-1:0]  pop_q,   pop_d;
  logic [NUM_OUT-1:0] push_q,  push_d;
  logic [DATA_W-1:0]  data_q,  data_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   ptr_q,   ptr_d;

  logic               gnt_valid;
  logic [IDX_W-1:0]   gnt_idx;

  // An input popped last cycle still shows its old head, so it sits out one cycle.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_in
      assign head_w[gi] = head_data[gi*DATA_W +: DATA_W];
      assign cls[gi]    = head_data[gi*DATA_W + CLASS_LSB +: CLASS_W];
      assign elig[gi]   = !fifo_empty[gi] && !almost_full[cls[gi]] && !pop_q[gi];
    end
  endgenerate

  arbitro_rr_pick #(
    .N     (NUM_IN),
    .IDX_W (IDX_W)
  ) u_pick (
    .elig      (elig),
    .ptr       (ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_comb begin
    pop_d   = '0;
    push_d  = '0;
    data_d  = data_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    if (enable && gnt_valid) begin
      pop_d[gnt_idx]       = 1'b1;
      push_d[cls[gnt_idx]] = 1'b1;
      data_d               = head_w[gnt_idx];
      grant_d              = gnt_idx;
`ifdef ARB_STRICT_PRIO_EN
      ptr_d                = '0;
`else
      ptr_d                = (gnt_idx == IDX_W'(NUM_IN - 1)) ? '0 : gnt_idx + 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pop_q   <= '0;
      push_q  <= '0;
      data_q  <= '0;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      pop_q   <= pop_d;
      push_q  <= push_d;
      data_q  <= data_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  assign pop       = pop_q;
  assign push      = push_q;
  assign data_out  = data_q;
  assign grant_idx = grant_q;

endmodule
